// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and default reset/bubble constants.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2,
    IF_KILL = 2'd3
  } if_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch front end: architectural PC, single-outstanding imem fetch,
// valid/ready presentation to decode, and redirect handling with in-flight squash.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  if_state_e   state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = align_word(redirect_pc_i);
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IF_IDLE;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      case (state)
        IF_IDLE: begin
          // Any stray ack seen here belongs to a request killed by reset.
          if (redirect_i) begin
            pc_q   <= target;
            addr_q <= target;
          end
          state <= IF_REQ;
        end
        IF_REQ: begin
          if (redirect_i) begin
            pc_q <= target;
            if (imem_ack_i) begin
              addr_q <= target;
              state  <= IF_REQ;
            end else begin
              // Old request is still on the bus; it must complete before refetching.
              state <= IF_KILL;
            end
          end else if (imem_ack_i) begin
            inst_q <= imem_rdata_i;
            state  <= IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (redirect_i) begin
            pc_q   <= target;
            addr_q <= target;
            state  <= IF_REQ;
          end else if (inst_ready_i) begin
            pc_q   <= pc_inc;
            addr_q <= pc_inc;
            state  <= IF_REQ;
          end
        end
        IF_KILL: begin
          if (redirect_i) begin
            pc_q <= target;
            if (imem_ack_i) begin
              addr_q <= target;
              state  <= IF_REQ;
            end
          end else if (imem_ack_i) begin
            addr_q <= pc_q;
            state  <= IF_REQ;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign imem_req_o   = (state == IF_REQ) || (state == IF_KILL);
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (state == IF_HOLD);
  assign inst_o       = (state == IF_HOLD) ? inst_q : NOP_INST;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: each step drives inputs, clocks once, and checks
// the registered-state outputs 1 time unit after the rising edge.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int errors = 0;
  int checks = 0;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b0;
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_pc", pc_o, 32'h0);

    // Streaming fetch with zero-wait acks and decode always ready.
    rst = 1'b0; inst_ready_i = 1'b1;
    tick();
    check("s0_req", {31'd0, imem_req_o}, 32'd1);
    check("s0_addr", imem_addr_o, 32'h0);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0113;
    tick(); imem_ack_i = 1'b0;
    check("s0_valid", {31'd0, inst_valid_o}, 32'd1);
    check("s0_inst", inst_o, 32'h0000_0113);
    check("s0_pc", pc_o, 32'h0);
    check("s0_noreq", {31'd0, imem_req_o}, 32'd0);
    tick();
    check("s1_addr", imem_addr_o, 32'h4);
    check("s1_novalid", {31'd0, inst_valid_o}, 32'd0);
    check("s1_nop", inst_o, 32'h0000_0013);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0213;
    tick(); imem_ack_i = 1'b0;
    check("s1_pc", pc_o, 32'h4);
    check("s1_inst", inst_o, 32'h0000_0213);
    tick();
    check("s2_addr", imem_addr_o, 32'h8);

    // Decode stall in HOLD.
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0050_0093; inst_ready_i = 1'b0;
    tick(); imem_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_inst", inst_o, 32'h0050_0093);
      check("stall_pc", pc_o, 32'h8);
      check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      check("stall_noreq", {31'd0, imem_req_o}, 32'd0);
      tick();
    end
    inst_ready_i = 1'b1;
    tick();
    check("stall_next_addr", imem_addr_o, 32'hC);
    check("stall_next_req", {31'd0, imem_req_o}, 32'd1);

    // Redirect in HOLD (unaligned target gets word-aligned).
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0313;
    tick(); imem_ack_i = 1'b0; inst_ready_i = 1'b0;
    check("h_pc", pc_o, 32'hC);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick(); redirect_i = 1'b0;
    check("hredir_addr", imem_addr_o, 32'h100);
    check("hredir_pc", pc_o, 32'h100);
    check("hredir_valid", {31'd0, inst_valid_o}, 32'd0);
    check("hredir_req", {31'd0, imem_req_o}, 32'd1);

    // Redirect plus ready in the same HOLD cycle: redirect wins over pc+4.
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0413;
    tick(); imem_ack_i = 1'b0;
    check("h2_pc", pc_o, 32'h100);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; inst_ready_i = 1'b1;
    tick(); redirect_i = 1'b0;
    check("hrdy_addr", imem_addr_o, 32'h100);
    check("hrdy_pc", pc_o, 32'h100);
    check("hrdy_valid", {31'd0, inst_valid_o}, 32'd0);

    // Redirect and ack in the same REQ cycle: data dropped.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0010;
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick(); redirect_i = 1'b0; imem_ack_i = 1'b0;
    check("rack_addr", imem_addr_o, 32'h10);
    check("rack_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rack_inst", inst_o, 32'h0000_0013);
    check("rack_req", {31'd0, imem_req_o}, 32'd1);

    // Redirect during outstanding REQ, ack delayed 3 cycles.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    tick(); redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("kill_addr", imem_addr_o, 32'h10);
      check("kill_req", {31'd0, imem_req_o}, 32'd1);
      check("kill_valid", {31'd0, inst_valid_o}, 32'd0);
      if (i < 2) tick();
    end
    check("kill_pc", pc_o, 32'h200);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    tick(); imem_ack_i = 1'b0;
    check("kill_next_addr", imem_addr_o, 32'h200);
    check("kill_next_valid", {31'd0, inst_valid_o}, 32'd0);

    // Two redirects while in KILL: latest one is fetched.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    tick();
    redirect_pc_i = 32'h0000_0400;
    tick(); redirect_i = 1'b0;
    check("k2_addr", imem_addr_o, 32'h200);
    check("k2_pc", pc_o, 32'h400);
    imem_ack_i = 1'b1;
    tick(); imem_ack_i = 1'b0;
    check("k2_next_addr", imem_addr_o, 32'h400);

    // Redirect coinciding with ack while in KILL.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0500;
    tick();
    redirect_pc_i = 32'h0000_0604; imem_ack_i = 1'b1;
    tick(); redirect_i = 1'b0; imem_ack_i = 1'b0;
    check("kack_addr", imem_addr_o, 32'h604);
    check("kack_pc", pc_o, 32'h604);
    check("kack_valid", {31'd0, inst_valid_o}, 32'd0);

    // PC wrap at the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; imem_ack_i = 1'b1;
    tick(); redirect_i = 1'b0;
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    imem_rdata_i = 32'h0000_0713;
    tick(); imem_ack_i = 1'b0;
    check("wrap_hold_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_addr", imem_addr_o, 32'h0);
    check("wrap_next_pc", pc_o, 32'h0);

    // Move to a non-reset PC, then pulse reset mid-request.
    imem_ack_i = 1'b1;
    tick(); imem_ack_i = 1'b0;
    tick();
    check("pre_rst_addr", imem_addr_o, 32'h4);
    rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_addr", imem_addr_o, 32'h0);
    imem_ack_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_req", {31'd0, imem_req_o}, 32'd1);
    check("post_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("post_rst_addr", imem_addr_o, 32'h0);
    imem_ack_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
